// File: rtl/snake_step_ctrl.sv
// Snake game step controller: game FSM, step-rate divider, direction latch and head tracking.
// Optional build macro SNAKE_WALL_WRAP_EN makes the head wrap at the matrix edges instead of ending the game.
module snake_step_ctrl #(
    parameter int TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       collide,
    input  logic       apple_hit,
    output logic       step,
    output logic       grow,
    output logic [1:0] dir,
    output logic [3:0] head_x,
    output logic [3:0] head_y,
    output logic [7:0] score,
    output logic       game_over,
    output logic [1:0] state
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_dir;
    logic [1:0]      r_pending;
    logic [3:0]      r_x;
    logic [3:0]      r_y;
    logic [7:0]      r_score;
    logic            r_grow;

    logic            w_load;
    logic            w_run;
    logic            w_step;
    logic            w_key_valid;
    logic [1:0]      w_key_dir;
    logic [1:0]      w_pend_next;
    logic [3:0]      w_nx;
    logic [3:0]      w_ny;
    logic            w_edge;
    logic            w_wall_out;
    logic            w_end;
    logic            w_advance;

    assign w_load = start && (r_state == S_IDLE || r_state == S_OVER);
    assign w_run  = (r_state == S_RUN);
    assign w_step = w_run && (r_cnt == CNT_MAX);

    always_comb begin
        w_key_valid = 1'b1;
        w_key_dir   = D_UP;
        if (key_up)         w_key_dir = D_UP;
        else if (key_down)  w_key_dir = D_DOWN;
        else if (key_left)  w_key_dir = D_LEFT;
        else if (key_right) w_key_dir = D_RIGHT;
        else                w_key_valid = 1'b0;
    end

    // Opposite directions differ only in bit 0; the pending value never opposes r_dir.
    assign w_pend_next = (w_key_valid && (w_key_dir != (r_dir ^ 2'b01))) ? w_key_dir : r_pending;

    always_comb begin
        w_nx   = r_x;
        w_ny   = r_y;
        w_edge = 1'b0;
        case (w_pend_next)
            D_UP:    begin w_ny = r_y - 4'd1; w_edge = (r_y == 4'd0);  end
            D_DOWN:  begin w_ny = r_y + 4'd1; w_edge = (r_y == 4'd15); end
            D_LEFT:  begin w_nx = r_x - 4'd1; w_edge = (r_x == 4'd0);  end
            default: begin w_nx = r_x + 4'd1; w_edge = (r_x == 4'd15); end
        endcase
    end

`ifdef SNAKE_WALL_WRAP_EN
    assign w_wall_out = 1'b0;
`else
    assign w_wall_out = w_edge;
`endif

    assign w_end     = w_step && (collide || w_wall_out);
    assign w_advance = w_step && !w_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN: begin
                if (w_end)      w_state_next = S_OVER;
                else if (pause) w_state_next = S_PAUSE;
            end
            S_PAUSE: if (pause) w_state_next = S_RUN;
            default: if (start) w_state_next = S_RUN;
        endcase
    end

    always_comb begin
        step      = w_step;
        game_over = (r_state == S_OVER);
        state     = r_state;
    end

    // A non-step pause pulse freezes the count on the cycle it arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_dir     <= D_RIGHT;
            r_pending <= D_RIGHT;
            r_x       <= 4'd8;
            r_y       <= 4'd8;
            r_score   <= 8'd0;
            r_grow    <= 1'b0;
        end else begin
            r_grow <= w_advance && apple_hit;
            if (w_load) begin
                r_cnt     <= '0;
                r_dir     <= D_RIGHT;
                r_pending <= D_RIGHT;
                r_x       <= 4'd8;
                r_y       <= 4'd8;
                r_score   <= 8'd0;
            end else if (w_run) begin
                r_pending <= w_pend_next;
                if (w_step) begin
                    r_cnt <= '0;
                    if (w_advance) begin
                        r_x   <= w_nx;
                        r_y   <= w_ny;
                        r_dir <= w_pend_next;
                        if (apple_hit && (r_score != 8'hFF)) r_score <= r_score + 8'd1;
                    end
                end else if (!pause) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign grow   = r_grow;
    assign dir    = r_dir;
    assign head_x = r_x;
    assign head_y = r_y;
    assign score  = r_score;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Bench for snake_step_ctrl with TICK_DIV=4: directed scenarios plus a random run against a game model.
module tb_snake_step_ctrl;

    localparam int TD = 4;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_OVER = 3;
    localparam logic [22:0] RST_VEC = {1'b0, 1'b0, 2'd3, 4'd8, 4'd8, 8'd0, 1'b0, 2'd0};

    logic clk = 1'b0;
    logic reset, start, pause, key_up, key_down, key_left, key_right, collide, apple_hit;
    logic step, grow, game_over;
    logic [1:0] dir, state;
    logic [3:0] head_x, head_y;
    logic [7:0] score;
    logic [22:0] obs_vec;

    int checks = 0;
    int errors = 0;

    int m_state, m_cnt, m_x, m_y, m_dir, m_pend, m_score;
    bit m_grow;
    bit exp_step, obs_step;
    int dx[4]  = '{0, 0, -1, 1};
    int dy[4]  = '{-1, 1, 0, 0};
    int opp[4] = '{1, 0, 3, 2};

    snake_step_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .collide(collide), .apple_hit(apple_hit),
        .step(step), .grow(grow), .dir(dir), .head_x(head_x), .head_y(head_y),
        .score(score), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    assign obs_vec = {step, grow, dir, head_x, head_y, score, game_over, state};

    function automatic void model_reset();
        m_state = ST_IDLE; m_cnt = 0; m_x = 8; m_y = 8;
        m_dir = 3; m_pend = 3; m_score = 0; m_grow = 1'b0;
    endfunction

    function automatic logic [22:0] model_vec();
        return {1'(m_state == ST_RUN && m_cnt == TD - 1), m_grow, 2'(m_dir), 4'(m_x), 4'(m_y),
                8'(m_score), 1'(m_state == ST_OVER), 2'(m_state)};
    endfunction

    function automatic void model_cycle(input bit st, input bit pa, input bit [3:0] k,
                                        input bit col, input bit app);
        int kd, nx, ny;
        bit out, stp;
        stp = (m_state == ST_RUN && m_cnt == TD - 1);
        exp_step = stp;
        m_grow = 1'b0;
        case (m_state)
            ST_IDLE, ST_OVER: begin
                if (st) begin
                    m_state = ST_RUN; m_x = 8; m_y = 8; m_dir = 3; m_pend = 3; m_score = 0; m_cnt = 0;
                end
            end
            ST_PAUSE: if (pa) m_state = ST_RUN;
            default: begin
                kd = k[3] ? 0 : k[2] ? 1 : k[1] ? 2 : k[0] ? 3 : -1;
                if (kd >= 0 && kd != opp[m_dir]) m_pend = kd;
                if (stp) begin
                    m_cnt = 0;
                    nx = m_x + dx[m_pend];
                    ny = m_y + dy[m_pend];
`ifdef SNAKE_WALL_WRAP_EN
                    out = 1'b0;
                    nx = (nx + 16) % 16;
                    ny = (ny + 16) % 16;
`else
                    out = (nx < 0 || nx > 15 || ny < 0 || ny > 15);
`endif
                    if (col || out) m_state = ST_OVER;
                    else begin
                        m_x = nx; m_y = ny; m_dir = m_pend;
                        if (app) begin
                            m_grow = 1'b1;
                            if (m_score < 255) m_score++;
                        end
                        if (pa) m_state = ST_PAUSE;
                    end
                end else if (pa) m_state = ST_PAUSE;
                else m_cnt++;
            end
        endcase
    endfunction

    task automatic tick(input bit st, input bit pa, input bit [3:0] k, input bit col, input bit app);
        start = st; pause = pa; {key_up, key_down, key_left, key_right} = k;
        collide = col; apple_hit = app;
        #1;
        obs_step = step;
        model_cycle(st, pa, k, col, app);
        @(posedge clk); #1;
        start = 0; pause = 0; {key_up, key_down, key_left, key_right} = 4'b0;
        collide = 0; apple_hit = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs_vec !== RST_VEC) begin
            errors++; $display("FAIL reset_values got %h expected %h", obs_vec, RST_VEC);
        end
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            checks++;
            if (obs_vec !== RST_VEC || obs_step !== 1'b0) begin
                errors++; $display("FAIL idle_hold cycle %0d got %h expected %h", c, obs_vec, RST_VEC);
            end
        end
    endtask

    task automatic test_run_basic();
        tick(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
            checks++;
            if (obs_step !== ((c % 4) == 0)) begin
                errors++; $display("FAIL step_timing cycle %0d got %b expected %b", c, obs_step, (c % 4) == 0);
            end
            if ((c % 4) == 0) begin
                checks++;
                if (head_x !== 4'(8 + c / 4) || head_y !== 4'd8) begin
                    errors++; $display("FAIL head_basic cycle %0d got %0d,%0d expected %0d,8", c, head_x, head_y, 8 + c / 4);
                end
            end
        end
    endtask

    task automatic test_reversal();
        tick(1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
        checks++;
        if (dir !== 2'd3) begin
            errors++; $display("FAIL dir_before_step got %0d expected 3", dir);
        end
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++;
        if (obs_step !== 1'b1 || dir !== 2'd3 || head_x !== 4'd12 || head_y !== 4'd8) begin
            errors++; $display("FAIL left_rejected got step %b dir %0d head %0d,%0d expected 1 3 12,8", obs_step, dir, head_x, head_y);
        end
        tick(1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++;
        if (obs_step !== 1'b1 || dir !== 2'd0 || head_x !== 4'd12 || head_y !== 4'd7) begin
            errors++; $display("FAIL turn_up got step %b dir %0d head %0d,%0d expected 1 0 12,7", obs_step, dir, head_x, head_y);
        end
    endtask

    task automatic test_apple();
        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < 4; t++) begin
                tick(1'b0, 1'b0, 4'b0, 1'b0, (t == 3) ? 1'b1 : 1'($urandom_range(0, 1)));
                if (t == 0 && r > 0) begin
                    checks++;
                    if (grow !== 1'b0) begin
                        errors++; $display("FAIL grow_width round %0d got %b expected 0", r, grow);
                    end
                end
            end
            checks++;
            if (obs_step !== 1'b1 || grow !== 1'b1 || score !== 8'(r + 1)) begin
                errors++; $display("FAIL apple round %0d got step %b grow %b score %0d expected 1 1 %0d", r, obs_step, grow, score, r + 1);
            end
        end
        for (int t = 0; t < 3; t++) tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'b0, 1'b1, 1'b1);
        checks++;
        if (state !== 2'd3 || game_over !== 1'b1 || score !== 8'd3 || head_x !== 4'd12 || head_y !== 4'd4 || dir !== 2'd0) begin
            errors++; $display("FAIL collide got state %0d go %b score %0d head %0d,%0d dir %0d expected 3 1 3 12,4 0", state, game_over, score, head_x, head_y, dir);
        end
        tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++;
        if (grow !== 1'b0 || state !== 2'd3) begin
            errors++; $display("FAIL collide_no_grow got grow %b state %0d expected 0 3", grow, state);
        end
    endtask

    task automatic test_pause();
        apply_reset();
        tick(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick(c == 4, 1'b0, 4'b0, 1'b0, 1'b0);
            checks++;
            if (state !== 2'd2 || obs_step !== 1'b0 || head_x !== 4'd8 || head_y !== 4'd8) begin
                errors++; $display("FAIL paused cycle %0d got state %0d step %b head %0d,%0d expected 2 0 8,8", c, state, obs_step, head_x, head_y);
            end
        end
        tick(1'b0, 1'b1, 4'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            tick(1'b0, c == 3, 4'b0, 1'b0, 1'b0);
            checks++;
            if (obs_step !== (c == 3)) begin
                errors++; $display("FAIL resume_step cycle %0d got %b expected %b", c, obs_step, c == 3);
            end
        end
        checks++;
        if (head_x !== 4'd9 || state !== 2'd2) begin
            errors++; $display("FAIL pause_on_step got head_x %0d state %0d expected 9 2", head_x, state);
        end
        tick(1'b0, 1'b1, 4'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL resume got state %0d expected 1", state);
        end
    endtask

    task automatic test_wall();
        apply_reset();
        tick(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        for (int c = 0; c < 28; c++) tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++;
        if (head_x !== 4'd15 || state !== 2'd1) begin
            errors++; $display("FAIL reach_edge got head_x %0d state %0d expected 15 1", head_x, state);
        end
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++;
`ifdef SNAKE_WALL_WRAP_EN
        if (obs_step !== 1'b1 || head_x !== 4'd0 || state !== 2'd1 || game_over !== 1'b0) begin
            errors++; $display("FAIL wall_wrap got step %b head_x %0d state %0d go %b expected 1 0 1 0", obs_step, head_x, state, game_over);
        end
`else
        if (obs_step !== 1'b1 || head_x !== 4'd15 || state !== 2'd3 || game_over !== 1'b1) begin
            errors++; $display("FAIL wall_over got step %b head_x %0d state %0d go %b expected 1 15 3 1", obs_step, head_x, state, game_over);
        end
`endif
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        checks++;
        if (grow !== 1'b1) begin
            errors++; $display("FAIL grow_before_reset got %b expected 1", grow);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_vec !== RST_VEC) begin
            errors++; $display("FAIL reset_mid_grow got %h expected %h", obs_vec, RST_VEC);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        tick(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++;
        if (step !== 1'b1) begin
            errors++; $display("FAIL step_before_reset got %b expected 1", step);
        end
        apple_hit = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_vec !== RST_VEC) begin
            errors++; $display("FAIL reset_mid_step got %h expected %h", obs_vec, RST_VEC);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        apple_hit = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("FAIL idle_after_reset got state %0d expected 0", state);
        end
        tick(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++;
        if (obs_step !== 1'b1 || head_x !== 4'd9 || head_y !== 4'd8 || state !== 2'd1) begin
            errors++; $display("FAIL restart_run got step %b head %0d,%0d state %0d expected 1 9,8 1", obs_step, head_x, head_y, state);
        end
    endtask

    task automatic test_random();
        bit st, pa, col, app;
        bit [3:0] k;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            st  = (m_state == ST_IDLE || m_state == ST_OVER) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
            pa  = ($urandom_range(0, 29) == 0);
            k   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            col = ($urandom_range(0, 19) == 0);
            app = ($urandom_range(0, 2) == 0);
            tick(st, pa, k, col, app);
            checks++;
            if (obs_step !== exp_step || obs_vec !== model_vec()) begin
                errors++;
                $display("FAIL random cycle %0d got step %b vec %h expected step %b vec %h", c, obs_step, obs_vec, exp_step, model_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 0; pause = 0; collide = 0; apple_hit = 0;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_run_basic();
        test_reversal();
        test_apple();
        test_pause();
        test_wall();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snake_step_ctrl.md
SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clock cycles per snake step (legal 2..2^24).
REQ-002 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: start  in  1  one-cycle pulse, begin or restart game.
REQ-005 SHALL have ports: pause  in  1  one-cycle pulse, toggle RUN/PAUSE.
REQ-006 SHALL have ports: key_up, key_down, key_left, key_right  in  1 each  synchronized direction levels.
REQ-007 SHALL have ports: collide  in  1  head-into-body flag from grid datapath, valid in step cycle.
REQ-008 SHALL have ports: apple_hit  in  1  head-on-apple flag from grid datapath, valid in step cycle.
REQ-009 SHALL have ports: step  out  1  one-cycle strobe telling the grid datapath to advance.
REQ-010 SHALL have ports: grow  out  1  one-cycle strobe, tail not removed this step.
REQ-011 SHALL have ports: dir  out  2  committed direction, UP=0 DOWN=1 LEFT=2 RIGHT=3.
REQ-012 SHALL have ports: head_x, head_y  out  4 each  head column/row on 16x16 matrix.
REQ-013 SHALL have ports: score  out  8  apples eaten.
REQ-014 SHALL have ports: game_over  out  1  high while in OVER (selects end-screen pattern).
REQ-015 SHALL have ports: state  out  2  IDLE=0 RUN=1 PAUSE=2 OVER=3.

Function
REQ-016 FSM SHALL be: IDLE -start-> RUN; RUN -pause-> PAUSE; PAUSE -pause-> RUN; RUN -step with collide-> OVER; OVER -start-> RUN.
REQ-017 start in RUN or PAUSE, and pause in IDLE or OVER, SHALL be ignored.
REQ-018 start from IDLE or OVER SHALL load head (8,8), dir RIGHT, pending RIGHT, score 0, tick counter 0.
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 only in RUN, wrap to 0, freeze in PAUSE.
REQ-020 step SHALL be high exactly in the RUN cycle where the counter equals TICK_DIV-1; first step is TICK_DIV cycles after start.
REQ-021 Pending direction SHALL be latched every RUN cycle from keys, priority up>down>left>right; no key keeps pending.
REQ-022 A key opposite the committed dir SHALL be rejected (no 180-degree reversal), including after an intervening pending change.
REQ-023 On the step edge, dir SHALL take pending, and head SHALL move one cell in the new dir.
REQ-024 collide=1 in the step cycle SHALL go to OVER; head, dir, and score are held, and no grow occurs.
REQ-025 apple_hit=1 without collide in the step cycle SHALL pulse grow in the following cycle and increment score, saturating at 255.
REQ-026 pause coinciding with step SHALL complete the step (head/score update) and then enter PAUSE.
REQ-027 game_over SHALL equal (state==OVER); step and grow SHALL be 0 outside RUN, except for the grow pulse from REQ-025.

Reset
REQ-028 reset SHALL force, asynchronously: state IDLE, head (8,8), dir RIGHT, pending RIGHT, score 0, counter 0, step 0, grow 0, game_over 0.
REQ-029 reset asserted mid-step or mid-grow SHALL abort the pulse; no update completes.
REQ-030 After reset deassertion, the block SHALL stay in IDLE until start.

Configuration
REQ-031 With macro SNAKE_WALL_WRAP_EN defined, head movement SHALL wrap modulo 16 (x=15 RIGHT->0, y=0 UP->15).
REQ-032 Without SNAKE_WALL_WRAP_EN, a step that would leave the 0..15 range SHALL go to OVER, with head held, as for collide.

Verification (TICK_DIV=4)
REQ-033 Reset, start, no keys -> step at cycles 4, 8, 12 after start; head_x 9, 10, 11; head_y 8.
REQ-034 Committed RIGHT, key_left then key_up before step -> left rejected; next step dir=UP, head_y 8->7.
REQ-035 apple_hit with step, 3 times -> 3 grow pulses, each one cycle after step; score=3. collide+apple_hit together -> OVER, score unchanged.
REQ-036 Pause at counter=1, hold 10 cycles, pause again -> next step 3 cycles after resume; head unchanged while paused.
REQ-037 Head x=15 moving RIGHT, step -> with SNAKE_WALL_WRAP_EN head_x=0, state RUN; without it, state OVER, head_x=15, game_over=1.
REQ-038 Reset asserted asynchronously during the step cycle -> all outputs at reset values before the next edge; start -> normal run from (8,8).
